// File: rtl/dct_block_loader.sv
// Serial-to-parallel loader feeding the 8-point transform: double-buffered, 8 samples/block.
// Optional TWOS_TO_SM_EN converts two's-complement input samples to sign-magnitude.
module dct_block_loader #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  input  logic              IN_SYNC,
  output logic              IN_READY,
  input  logic              BLK_READY,
  output logic [DATA_W-1:0] O0,
  output logic [DATA_W-1:0] O1,
  output logic [DATA_W-1:0] O2,
  output logic [DATA_W-1:0] O3,
  output logic [DATA_W-1:0] O4,
  output logic [DATA_W-1:0] O5,
  output logic [DATA_W-1:0] O6,
  output logic [DATA_W-1:0] O7,
  output logic              BLK_VALID,
  output logic [CNT_W-1:0]  RESYNC_CNT
);

  typedef enum logic {FILL, FULL} state_t;

  state_t            state, state_n;
  logic [2:0]        idx;
  logic [DATA_W-1:0] fill [8];
  logic [DATA_W-1:0] ob   [8];
  logic [DATA_W-1:0] sample;
  logic              accept, xfer, resync;
  logic [CNT_W-1:0]  resync_cnt;

`ifdef TWOS_TO_SM_EN
  // Most negative input has no positive twin, so it clamps to the largest magnitude.
  function automatic logic [DATA_W-1:0] to_sm(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = -x;
    if (!x[DATA_W-1])
      to_sm = x;
    else if (x[DATA_W-2:0] == '0)
      to_sm = '1;
    else
      to_sm = {1'b1, neg[DATA_W-2:0]};
  endfunction

  assign sample = to_sm(IN_DATA);
`else
  assign sample = IN_DATA;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state <= FILL;
    else       state <= state_n;
  end

  // In FULL the index is always 0, so a resync can only occur while filling.
  always_comb begin
    state_n  = state;
    IN_READY = (state == FILL) || BLK_READY;
    accept   = IN_VALID && IN_READY;
    xfer     = (state == FULL) && BLK_READY;
    resync   = accept && IN_SYNC && (idx != 3'd0);
    if (xfer)
      state_n = FILL;
    if (accept && !resync && idx == 3'd7)
      state_n = FULL;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx        <= 3'd0;
      resync_cnt <= '0;
      BLK_VALID  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        fill[i] <= '0;
        ob[i]   <= '0;
      end
    end else begin
      BLK_VALID <= xfer;
      if (xfer)
        for (int i = 0; i < 8; i++) ob[i] <= fill[i];
      if (accept) begin
        if (resync) begin
          fill[0] <= sample;
          idx     <= 3'd1;
          if (resync_cnt != '1)
            resync_cnt <= resync_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          fill[idx] <= sample;
          idx       <= idx + 3'd1;
        end
      end
    end
  end

  assign O0 = ob[0];
  assign O1 = ob[1];
  assign O2 = ob[2];
  assign O3 = ob[3];
  assign O4 = ob[4];
  assign O5 = ob[5];
  assign O6 = ob[6];
  assign O7 = ob[7];
  assign RESYNC_CNT = resync_cnt;

endmodule

// File: tb/tb_dct_block_loader.sv
// Scoreboard bench for dct_block_loader: stimulus pushes expected blocks, a monitor pops on BLK_VALID.
// Conversion vectors follow TWOS_TO_SM_EN.
module tb_dct_block_loader;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 8;

  logic              CLK = 1'b0;
  logic              RESET, IN_VALID, IN_SYNC, BLK_READY, IN_READY, BLK_VALID;
  logic [DATA_W-1:0] IN_DATA, O0, O1, O2, O3, O4, O5, O6, O7;
  logic [CNT_W-1:0]  RESYNC_CNT;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          stalls = 0;
  logic [95:0] expQ[$];
  int          pulseCyc[$];

  dct_block_loader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_SYNC(IN_SYNC), .IN_READY(IN_READY), .BLK_READY(BLK_READY),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6), .O7(O7),
    .BLK_VALID(BLK_VALID), .RESYNC_CNT(RESYNC_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [95:0] outBlk();
    return {O0, O1, O2, O3, O4, O5, O6, O7};
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Holds one sample until it is accepted; leaves IN_VALID low right after the accepting edge.
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic s);
    int   n;
    logic r;
    n = 0;
    IN_DATA  = d;
    IN_SYNC  = s;
    IN_VALID = 1'b1;
    do begin
      @(negedge CLK);
      r = IN_READY;
      @(posedge CLK);
      #1;
      n++;
    end while (!r && n < 100);
    if (!r) checkOutput("accept_timeout", 96'(n), 96'(0));
    stalls += n - 1;
    IN_VALID = 1'b0;
    IN_SYNC  = 1'b0;
  endtask

  task automatic sendBlock(input logic [95:0] blk, input logic sync0);
    expQ.push_back(blk);
    for (int i = 0; i < 8; i++)
      applyStimulus(blk[95-12*i -: 12], (i == 0) ? sync0 : 1'b0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput("drain", 96'(expQ.size()), 96'(0));
  endtask

  // Monitor: every BLK_VALID pulse must match the oldest outstanding expected block.
  initial begin
    logic [95:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (!RESET && BLK_VALID) begin
        pulseCyc.push_back(cyc);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_block", outBlk(), 96'(0));
        end else begin
          e = expQ.pop_front();
          checkOutput("block", outBlk(), e);
        end
      end
    end
  end

  initial begin
    logic [95:0] b1, b2, b3, conv_in, conv_exp;
    int s0;
    RESET = 1'b1; IN_VALID = 1'b0; IN_SYNC = 1'b0; IN_DATA = '0; BLK_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("reset_O", outBlk(), 96'(0));
    checkOutput("reset_blk_valid", 96'(BLK_VALID), 96'(0));
    checkOutput("reset_in_ready", 96'(IN_READY), 96'(1));
    checkOutput("reset_resync_cnt", 96'(RESYNC_CNT), 96'(0));
    @(posedge CLK);
    #1;

    // Single block
    BLK_READY = 1'b1;
    pulseCyc.delete();
    sendBlock({12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007, 12'h008}, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("single_pulse_count", 96'(pulseCyc.size()), 96'(1));
    checkOutput("single_hold", outBlk(), {12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007, 12'h008});

    // Back-to-back: 24 continuous samples
    pulseCyc.delete();
    s0 = stalls;
    sendBlock({12'h100, 12'h101, 12'h102, 12'h103, 12'h104, 12'h105, 12'h106, 12'h107}, 1'b0);
    sendBlock({12'h108, 12'h109, 12'h10A, 12'h10B, 12'h10C, 12'h10D, 12'h10E, 12'h10F}, 1'b0);
    sendBlock({12'h110, 12'h111, 12'h112, 12'h113, 12'h114, 12'h115, 12'h116, 12'h117}, 1'b0);
    waitDrain();
    checkOutput("b2b_stalls", 96'(stalls - s0), 96'(0));
    checkOutput("b2b_pulse_count", 96'(pulseCyc.size()), 96'(3));
    if (pulseCyc.size() == 3) begin
      checkOutput("b2b_spacing_1", 96'(pulseCyc[1] - pulseCyc[0]), 96'(8));
      checkOutput("b2b_spacing_2", 96'(pulseCyc[2] - pulseCyc[1]), 96'(8));
    end

    // Backpressure while block 2 completes
    b1 = {12'h200, 12'h201, 12'h202, 12'h203, 12'h204, 12'h205, 12'h206, 12'h207};
    b2 = {12'h210, 12'h211, 12'h212, 12'h213, 12'h214, 12'h215, 12'h216, 12'h217};
    b3 = {12'h220, 12'h221, 12'h222, 12'h223, 12'h224, 12'h225, 12'h226, 12'h227};
    sendBlock(b1, 1'b0);
    @(posedge CLK);
    #1;
    BLK_READY = 1'b0;
    sendBlock(b2, 1'b0);
    expQ.push_back(b3);
    IN_DATA = 12'h220; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("bp_in_ready", 96'(IN_READY), 96'(0));
      checkOutput("bp_hold", outBlk(), b1);
      checkOutput("bp_blk_valid", 96'(BLK_VALID), 96'(0));
      @(posedge CLK);
      #1;
    end
    BLK_READY = 1'b1;
    @(negedge CLK);
    checkOutput("bp_release_ready", 96'(IN_READY), 96'(1));
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    checkOutput("bp_release_block", outBlk(), b2);
    for (int i = 1; i < 8; i++) applyStimulus(b3[95-12*i -: 12], 1'b0);
    waitDrain();

    // Sync on index 0 is a normal write
    sendBlock({12'h0C0, 12'h0C1, 12'h0C2, 12'h0C3, 12'h0C4, 12'h0C5, 12'h0C6, 12'h0C7}, 1'b1);
    waitDrain();
    checkOutput("sync_idx0_cnt", 96'(RESYNC_CNT), 96'(0));

    // Resync: 3 stray samples, then a synced block; repeated to saturation
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 3; i++) applyStimulus(12'(12'h300 + i), 1'b0);
      sendBlock({12'h0AA, 12'h0B1, 12'h0B2, 12'h0B3, 12'h0B4, 12'h0B5, 12'h0B6, 12'h0B7}, 1'b1);
      if (k == 0) checkOutput("resync_cnt_1", 96'(RESYNC_CNT), 96'(1));
    end
    waitDrain();
    checkOutput("resync_cnt_sat", 96'(RESYNC_CNT), 96'(255));

    // Reset mid-block discards the partial fill
    for (int i = 0; i < 4; i++) applyStimulus(12'(12'h400 + i), 1'b0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    checkOutput("midreset_O", outBlk(), 96'(0));
    checkOutput("midreset_cnt", 96'(RESYNC_CNT), 96'(0));
    sendBlock({12'h500, 12'h501, 12'h502, 12'h503, 12'h504, 12'h505, 12'h506, 12'h507}, 1'b0);
    waitDrain();

    // Input conversion
    conv_in = {12'hFFF, 12'h800, 12'h005, 12'h000, 12'h7FF, 12'hFFE, 12'h001, 12'h801};
`ifdef TWOS_TO_SM_EN
    conv_exp = {12'h801, 12'hFFF, 12'h005, 12'h000, 12'h7FF, 12'h802, 12'h001, 12'hFFF};
`else
    conv_exp = conv_in;
`endif
    expQ.push_back(conv_exp);
    for (int i = 0; i < 8; i++) applyStimulus(conv_in[95-12*i -: 12], 1'b0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
